// File: rtl/xadac_pkg.sv
// Shared types and constants for the xadac accelerator interface and the
// vector bias unit. Field positions of the bias instruction live here.
package xadac_pkg;

  localparam int XLEN         = 64;
  localparam int SumWidth     = 32;
  localparam int MaxVecLen    = 8;
  localparam int VecLenWidth  = 4;
  localparam int IdWidth      = 5;
  localparam int NumRs        = 2;
  localparam int NumVs        = 3;
  localparam int VbiasModeLsb = 12;
  localparam int VecLenLsb    = 25;

  typedef logic [VecLenWidth-1:0]          VecLenT;
  typedef logic signed [SumWidth-1:0]      SumT;
  typedef logic [MaxVecLen*SumWidth-1:0]   VecDataT;
  typedef logic [XLEN-1:0]                 RegDataT;
  typedef logic [IdWidth-1:0]              IdT;
  typedef logic [31:0]                     InstrT;

  localparam SumT SumMax = {1'b0, {(SumWidth-1){1'b1}}};
  localparam SumT SumMin = {1'b1, {(SumWidth-1){1'b0}}};

  typedef enum logic [1:0] {
    BCAST = 2'd0,
    SADD  = 2'd1,
    VADD  = 2'd2,
    RSVD  = 2'd3
  } VbiasModeT;

  typedef struct packed {
    IdT    id;
    InstrT instr;
  } DecReqT;

  typedef struct packed {
    IdT               id;
    logic             accept;
    logic             rd_clobber;
    logic             vd_clobber;
    logic [NumRs-1:0] rs_read;
    logic [NumVs-1:0] vs_read;
  } DecRspT;

  typedef struct packed {
    InstrT                     instr;
    RegDataT [NumRs-1:0]       rs_data;
    VecDataT [NumVs-1:0]       vs_data;
  } ExeReqT;

  typedef struct packed {
    IdT      id;
    VecDataT vd;
  } ExeRspT;

  function automatic VbiasModeT instr_mode(input InstrT instr);
    return VbiasModeT'(instr[VbiasModeLsb +: 2]);
  endfunction

  function automatic VecLenT instr_vlen(input InstrT instr);
    return instr[VecLenLsb +: VecLenWidth];
  endfunction

endpackage

// File: rtl/xadac_if.sv
// xadac accelerator interface: decode handshake plus execute request/response.
interface xadac_if;
  import xadac_pkg::*;

  logic   dec_req_valid;
  logic   dec_req_ready;
  DecReqT dec_req;
  logic   dec_rsp_valid;
  logic   dec_rsp_ready;
  DecRspT dec_rsp;

  logic   exe_req_valid;
  logic   exe_req_ready;
  IdT     exe_req_id;
  ExeReqT exe_req;
  logic   exe_rsp_valid;
  logic   exe_rsp_ready;
  ExeRspT exe_rsp;

  modport slv (
    input  dec_req_valid, dec_req, dec_rsp_ready,
           exe_req_valid, exe_req_id, exe_req, exe_rsp_ready,
    output dec_req_ready, dec_rsp_valid, dec_rsp,
           exe_req_ready, exe_rsp_valid, exe_rsp
  );

  modport mst (
    output dec_req_valid, dec_req, dec_rsp_ready,
           exe_req_valid, exe_req_id, exe_req, exe_rsp_ready,
    input  dec_req_ready, dec_rsp_valid, dec_rsp,
           exe_req_ready, exe_rsp_valid, exe_rsp
  );

endinterface

// File: rtl/xadac_vbias_lane.sv
// One bias lane: broadcast, or signed add with optional saturation.
// Disabled lanes and the reserved mode produce zero.
module xadac_vbias_lane
  import xadac_pkg::*;
#(
  parameter bit Saturate = 1'b1
) (
  input  VbiasModeT mode_i,
  input  SumT       a_i,
  input  SumT       b_i,
  input  SumT       s_i,
  input  logic      en_i,
  output SumT       sum_o
);

  SumT                 addend;
  logic [SumWidth:0]   wide;
  logic                ovf;

  assign addend = (mode_i == VADD) ? b_i : s_i;
  assign wide   = {a_i[SumWidth-1], a_i} + {addend[SumWidth-1], addend};
  // Sign-extended sum disagreeing in its top two bits means the add overflowed.
  assign ovf    = wide[SumWidth] != wide[SumWidth-1];

  // NOTE: sum_o is defaulted before the case so no path leaves it unassigned; otherwise a latch is inferred.
  always_comb begin
    sum_o = '0;
    if (en_i) begin
      case (mode_i)
        BCAST: sum_o = s_i;
        SADD, VADD: begin
          if (Saturate && ovf) sum_o = wide[SumWidth] ? SumMin : SumMax;
          else                 sum_o = wide[SumWidth-1:0];
        end
        default: sum_o = '0;
      endcase
    end
  end

endmodule

// File: rtl/xadac_vbias_pipe.sv
// Pipelined vector bias unit on the xadac slave port: combinational decode and
// a Stages-deep stall-all execute pipeline with in-order responses.
module xadac_vbias_pipe
  import xadac_pkg::*;
#(
  parameter int Stages   = 2,
  parameter bit Saturate = 1'b1,
  parameter int MaxLanes = MaxVecLen
) (
  input logic   clk,
  input logic   rst,
  xadac_if.slv  slv
);

  localparam int Lanes    = (MaxLanes < MaxVecLen) ? MaxLanes : MaxVecLen;
  localparam int OccWidth = $clog2(Stages + 1);

  VbiasModeT dec_mode;
  logic      dec_acc;

  assign dec_mode          = instr_mode(slv.dec_req.instr);
  assign dec_acc           = dec_mode != RSVD;
  assign slv.dec_rsp_valid = slv.dec_req_valid;
  assign slv.dec_req_ready = slv.dec_rsp_valid && slv.dec_rsp_ready;

  always_comb begin
    slv.dec_rsp            = '0;
    slv.dec_rsp.id         = slv.dec_req.id;
    slv.dec_rsp.accept     = dec_acc;
    slv.dec_rsp.vd_clobber = dec_acc;
    slv.dec_rsp.rs_read[0] = (dec_mode == BCAST) || (dec_mode == SADD);
    slv.dec_rsp.vs_read[0] = (dec_mode == SADD) || (dec_mode == VADD);
    slv.dec_rsp.vs_read[1] = (dec_mode == VADD);
  end

  VbiasModeT exe_mode;
  VecLenT    exe_vlen;
  SumT       exe_s;
  VecDataT   vd_d;

  assign exe_mode = instr_mode(slv.exe_req.instr);
  assign exe_vlen = instr_vlen(slv.exe_req.instr);
  assign exe_s    = slv.exe_req.rs_data[0][SumWidth-1:0];

  for (genvar i = 0; i < MaxVecLen; i++) begin : g_lane
    if (i < Lanes) begin : g_on
      SumT lane_sum;
      xadac_vbias_lane #(.Saturate(Saturate)) u_lane (
        .mode_i (exe_mode),
        .a_i    (slv.exe_req.vs_data[0][i*SumWidth +: SumWidth]),
        .b_i    (slv.exe_req.vs_data[1][i*SumWidth +: SumWidth]),
        .s_i    (exe_s),
        .en_i   (i < int'(exe_vlen)),
        .sum_o  (lane_sum)
      );
      assign vd_d[i*SumWidth +: SumWidth] = lane_sum;
    end else begin : g_off
      assign vd_d[i*SumWidth +: SumWidth] = '0;
    end
  end

  logic [Stages-1:0]   valid_q;
  IdT                  id_q [Stages];
  VecDataT             vd_q [Stages];
  logic [OccWidth-1:0] occ_q, occ_d;
  logic                advance, load, retire;

  // Any stall at the output freezes every stage, so bubbles are never squeezed out.
  assign advance           = !valid_q[Stages-1] || slv.exe_rsp_ready;
  assign load              = slv.exe_req_valid && advance;
  assign retire            = valid_q[Stages-1] && slv.exe_rsp_ready;
  assign slv.exe_req_ready = advance;
  assign slv.exe_rsp_valid = valid_q[Stages-1];
  assign slv.exe_rsp.id    = id_q[Stages-1];
  assign slv.exe_rsp.vd    = vd_q[Stages-1];

  // NOTE: non-blocking assignments let every stage capture its predecessor's pre-edge value in one shift.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      // NOTE: payload registers are cleared too so the bus never shows stale id/vd after reset.
      for (int k = 0; k < Stages; k++) begin
        id_q[k] <= '0;
        vd_q[k] <= '0;
      end
    end else if (advance) begin
      valid_q[0] <= slv.exe_req_valid;
      id_q[0]    <= slv.exe_req_id;
      vd_q[0]    <= vd_d;
      for (int k = 1; k < Stages; k++) begin
        valid_q[k] <= valid_q[k-1];
        id_q[k]    <= id_q[k-1];
        vd_q[k]    <= vd_q[k-1];
      end
    end
  end

  always_comb begin
    occ_d = occ_q;
    if (load && !retire)      occ_d = occ_q + 1'b1;
    else if (!load && retire) occ_d = occ_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) occ_q <= '0;
    else     occ_q <= occ_d;
  end

  occ_bound_a: assert property (@(posedge clk) disable iff (rst)
    occ_q <= OccWidth'(Stages));
  occ_empty_a: assert property (@(posedge clk) disable iff (rst)
    (occ_q == '0) |-> !slv.exe_rsp_valid);

endmodule
